// File: rtl/rat_checkpoint.sv
// ----------------------------------------------------------------------------
// rat_checkpoint
//
// Register alias table (arch -> phys tag map) with branch checkpoint storage.
// The branch buffer asks for a snapshot of the live map with Copy_RAT/tail_num
// and for a restore after a misprediction with Paste_RAT/head_num. A restore
// spends one RESTORE cycle during which rename is stalled.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   rename_valid/rd/tag      rename write of a new physical tag for rd
//   rs1_addr/rs2_addr        source architectural indices
//   rs1_tag/rs2_tag          combinational mappings, with same-cycle bypass
//   Copy_RAT, tail_num       snapshot the live map into slot tail_num
//   Paste_RAT, head_num      restore the live map from slot head_num
//   rat_stall                high during the RESTORE cycle
//   restore_done             pulse in the first IDLE cycle after RESTORE
//   ckpt_err                 pulse the cycle after a paste to an invalid slot
//   ckpt_count               number of valid checkpoint slots
// ----------------------------------------------------------------------------
module rat_checkpoint #(
    parameter int ARCH_REGS = 32,
    parameter int TAG_W     = 6,
    parameter int CKPT_N    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rename_valid,
    input  logic [4:0]       rename_rd,
    input  logic [TAG_W-1:0] rename_tag,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [TAG_W-1:0] rs2_tag,
    input  logic             Copy_RAT,
    input  logic [4:0]       tail_num,
    input  logic             Paste_RAT,
    input  logic [4:0]       head_num,
    output logic             rat_stall,
    output logic             restore_done,
    output logic             ckpt_err,
    output logic [5:0]       ckpt_count
);

    typedef logic [ARCH_REGS-1:0][TAG_W-1:0] map_t;

    typedef enum logic {
        IDLE,
        RESTORE
    } state_e;

    function automatic map_t identity_map();
        map_t m;
        for (int i = 0; i < ARCH_REGS; i++) begin
            m[i] = TAG_W'(i);
        end
        return m;
    endfunction

    state_e            state_q, state_d;
    map_t              map_q, map_d;
    map_t              map_renamed;
    logic [CKPT_N-1:0] ckpt_valid_q, ckpt_valid_d;
    logic [5:0]        ckpt_count_q, ckpt_count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    map_t              ckpt_mem [CKPT_N];
    logic              ckpt_we;
    map_t              ckpt_rdata;

    // Live map with this cycle's rename applied; also what a snapshot stores,
    // so a link-register write in the branch's own cycle survives recovery.
    always_comb begin
        map_renamed = map_q;
        if (rename_valid && rename_rd != '0) begin
            map_renamed[rename_rd] = rename_tag;
        end
    end

    assign ckpt_rdata = ckpt_mem[head_num];

    // NOTE: every always_comb output gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        map_d        = map_q;
        ckpt_valid_d = ckpt_valid_q;
        ckpt_count_d = ckpt_count_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        ckpt_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (Paste_RAT) begin
                    // Any paste flushes every checkpoint, mirroring the branch
                    // buffer; a same-cycle rename or copy is discarded.
                    ckpt_valid_d = '0;
                    ckpt_count_d = '0;
                    if (ckpt_valid_q[head_num]) begin
                        map_d   = ckpt_rdata;
                        state_d = RESTORE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    map_d = map_renamed;
                    if (Copy_RAT) begin
                        ckpt_we                = 1'b1;
                        ckpt_valid_d[tail_num] = 1'b1;
                        // Overwriting a valid slot does not add a checkpoint.
                        if (!ckpt_valid_q[tail_num] &&
                            ckpt_count_q != 6'(CKPT_N)) begin
                            ckpt_count_d = ckpt_count_q + 6'd1;
                        end
                    end
                end
            end
            RESTORE: begin
                // Rename, Copy_RAT and Paste_RAT are all ignored here.
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        map_d[0] = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            map_q        <= identity_map();
            ckpt_valid_q <= '0;
            ckpt_count_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            map_q        <= map_d;
            ckpt_valid_q <= ckpt_valid_d;
            ckpt_count_q <= ckpt_count_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // NOTE: checkpoint storage has no reset; a slot is only read after
    // ckpt_valid marks it written, so its contents are don't-care until then.
    always_ff @(posedge clk) begin
        if (ckpt_we) begin
            ckpt_mem[tail_num] <= map_renamed;
        end
    end

    function automatic logic [TAG_W-1:0] read_tag(input logic [4:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (rename_valid && rename_rd != '0 && addr == rename_rd) begin
            return rename_tag;
        end else begin
            return map_q[addr];
        end
    endfunction

    assign rs1_tag      = read_tag(rs1_addr);
    assign rs2_tag      = read_tag(rs2_addr);
    assign rat_stall    = (state_q == RESTORE);
    assign restore_done = done_q;
    assign ckpt_err     = err_q;
    assign ckpt_count   = ckpt_count_q;

endmodule

// File: doc/rat_checkpoint.md
Name: rat_checkpoint

Overview:
Register alias table with branch checkpoint storage. It is the consumer end of the branch buffer's Copy_RAT/tail_num and Paste_RAT/head_num protocol. On Copy_RAT it snapshots the live arch-to-phys map into slot tail_num. On Paste_RAT it restores the live map from slot head_num, so rename resumes from the pre-misprediction state. It sits in the rename stage beside the free list and feeds physical tags to the reservation stations.

Parameters:
ARCH_REGS, 32, number of architectural registers (index width 5)
TAG_W, 6, physical register tag width
CKPT_N, 32, checkpoint slots; must equal the branch buffer depth (index width 5)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
rename_valid  in  1  rename write enable this cycle
rename_rd  in  5  architectural destination
rename_tag  in  TAG_W  new physical tag for rename_rd
rs1_addr  in  5  source 1 architectural index
rs2_addr  in  5  source 2 architectural index
rs1_tag  out  TAG_W  combinational mapping of rs1_addr
rs2_tag  out  TAG_W  combinational mapping of rs2_addr
Copy_RAT  in  1  snapshot request from the branch buffer
tail_num  in  5  destination slot for the snapshot
Paste_RAT  in  1  restore request (misprediction)
head_num  in  5  source slot for the restore
rat_stall  out  1  rename must hold this cycle
restore_done  out  1  one-cycle pulse after the restore completes
ckpt_err  out  1  one-cycle pulse when Paste_RAT targets an invalid slot
ckpt_count  out  6  number of valid checkpoint slots

Behaviour:
- Reset (synchronous):
  - live map[i] = i (identity).
  - All ckpt_valid cleared.
  - State = IDLE.
  - rat_stall=0, restore_done=0, ckpt_err=0, ckpt_count=0.
  - Checkpoint contents are don't-care.
- Register x0:
  - map[0] is fixed at 0.
  - A rename write with rename_rd=0 is ignored.
  - rs*_addr=0 always returns 0.
- Reads: combinational from the live map. When rename_valid=1, rename_rd!=0 and rs*_addr==rename_rd, the read returns rename_tag (same-cycle bypass).
- Rename write: when rename_valid=1 in IDLE, map[rename_rd] <= rename_tag at the clock edge. The write is ignored in RESTORE.
- Copy_RAT=1 in IDLE and Paste_RAT=0:
  - ckpt[tail_num] <= live map including this cycle's rename write, because a JAL/JALR link-register write must survive recovery.
  - ckpt_valid[tail_num] <= 1.
  - An already-valid slot is overwritten silently; ckpt_count is unchanged in that case.
- Paste_RAT=1 in IDLE, slot valid:
  - live map <= ckpt[head_num], discarding any same-cycle rename write.
  - All ckpt_valid cleared; ckpt_count <= 0.
  - State -> RESTORE.
- Paste_RAT=1 in IDLE, slot invalid:
  - Live map untouched; ckpt_err pulses on the next cycle.
  - All ckpt_valid are still cleared, matching the branch buffer's flush.
  - State stays IDLE.
- Copy_RAT and Paste_RAT in the same cycle: Paste wins and Copy is dropped.
- FSM:
  - IDLE -> RESTORE on a valid paste.
  - RESTORE lasts exactly 1 cycle; in it rat_stall=1 and Copy_RAT is ignored.
  - RESTORE -> IDLE with restore_done=1 during the first IDLE cycle.
  - Paste_RAT arriving in RESTORE is ignored; the branch buffer deasserts it after one cycle.
- Latency:
  - Snapshot is visible for restore from the next cycle.
  - Restored mapping is visible on rs*_tag one cycle after the Paste_RAT edge, during RESTORE.
- ckpt_count: +1 per Copy_RAT to an invalid slot; saturates at 32.
- Reset mid-RESTORE: takes effect immediately and returns to the reset state.

Test Plan:
- Reset -> rs1_addr=5 gives rs1_tag=5; ckpt_count=0; rat_stall=0.
- Rename x5->40 with rs1_addr=5 the same cycle -> rs1_tag=40 (bypass); next cycle rs1_tag still 40. Rename x0->33 -> rs1_addr=0 gives 0.
- Rename x5->40, Copy_RAT tail_num=3, rename x5->41, Paste_RAT head_num=3 -> rat_stall=1 for 1 cycle, x5 reads 40, restore_done pulses, ckpt_count=0.
- Copy_RAT tail_num=7 in the same cycle as rename x1->50, then rename x1->51, then Paste head_num=7 -> x1 reads 50.
- Paste_RAT head_num=9 with no checkpoint taken -> ckpt_err=1 for one cycle, map unchanged, rat_stall=0.
- Copy_RAT tail_num=2 and Paste_RAT head_num=1 (slot 1 valid) in one cycle -> restore from slot 1, slot 2 invalid, ckpt_count=0; then assert rst during RESTORE -> identity map and IDLE.
